// File: rtl/fp_mul_round_pack.sv
// Normalize, round-to-nearest-even and pack stage of the single-precision FP multiplier.
// One operation in flight; fixed latency IDLE->NORM->ROUND->PACK->DONE.
module fp_mul_round_pack #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 24,
  parameter int BIAS  = 127
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2*MAN_W-1:0]     prod,
  input  logic                   sign_a,
  input  logic                   sign_b,
  input  logic [EXP_W-1:0]       exp_a,
  input  logic [EXP_W-1:0]       exp_b,
  input  logic                   a_zero,
  input  logic                   b_zero,
  input  logic                   a_inf,
  input  logic                   b_inf,
  input  logic                   a_nan,
  input  logic                   b_nan,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W-1:0] result,
  output logic                   flag_ovf,
  output logic                   flag_unf,
  output logic                   flag_inx,
  output logic                   flag_inv
);

  localparam int PW = 2 * MAN_W;
  localparam int EW = EXP_W + 2;
  localparam int RW = EXP_W + MAN_W;
  localparam logic signed [EW-1:0] E_ONE  = EW'(1);
  localparam logic signed [EW-1:0] E_ZERO = EW'(0);
  localparam logic signed [EW-1:0] E_MAX  = EW'((1 << EXP_W) - 1);
  localparam logic [RW-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-2){1'b0}}};

  typedef enum logic [2:0] {IDLE, NORM, ROUND, PACK, DONE} state_t;
  state_t state, state_nxt;

  logic [PW-1:0]         p_q;
  logic                  sgn_q;
  logic [EXP_W-1:0]      ea_q, eb_q;
  logic                  az_q, bz_q, ai_q, bi_q, an_q, bn_q;
  logic signed [EW-1:0]  e_q;
  logic [MAN_W-1:0]      m_q;
  logic                  g_q, s_q, inx_q;

  logic signed [EW-1:0]  e_base;
  logic [MAN_W:0]        m_inc;
  logic                  rnd_up;
  logic [RW-1:0]         res_nxt;
  logic                  ovf_nxt, unf_nxt, inx_nxt, inv_nxt;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid) state_nxt = NORM;
      NORM:    state_nxt = ROUND;
      ROUND:   state_nxt = PACK;
      PACK:    state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    e_base = EW'(ea_q) + EW'(eb_q) - EW'(BIAS);
    m_inc  = {1'b0, m_q} + {{MAN_W{1'b0}}, 1'b1};
    rnd_up = g_q & (s_q | m_q[0]);
  end

  // Special operands take priority over range checks; range checks use the rounded exponent.
  always_comb begin
    res_nxt = {sgn_q, e_q[EXP_W-1:0], m_q[MAN_W-2:0]};
    ovf_nxt = 1'b0;
    unf_nxt = 1'b0;
    inx_nxt = inx_q;
    inv_nxt = 1'b0;
    if (an_q | bn_q) begin
      res_nxt = QNAN;
      inx_nxt = 1'b0;
    end else if ((ai_q & bz_q) | (az_q & bi_q)) begin
      res_nxt = QNAN;
      inx_nxt = 1'b0;
      inv_nxt = 1'b1;
    end else if (ai_q | bi_q) begin
      res_nxt = {sgn_q, {EXP_W{1'b1}}, {(MAN_W-1){1'b0}}};
      inx_nxt = 1'b0;
    end else if (az_q | bz_q) begin
      res_nxt = {sgn_q, {(RW-1){1'b0}}};
      inx_nxt = 1'b0;
    end else if (e_q >= E_MAX) begin
      res_nxt = {sgn_q, {EXP_W{1'b1}}, {(MAN_W-1){1'b0}}};
      ovf_nxt = 1'b1;
      inx_nxt = 1'b1;
    end else if (e_q <= E_ZERO) begin
      res_nxt = {sgn_q, {(RW-1){1'b0}}};
      unf_nxt = 1'b1;
      inx_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      p_q   <= '0;
      sgn_q <= 1'b0;
      ea_q  <= '0;
      eb_q  <= '0;
      az_q  <= 1'b0;
      bz_q  <= 1'b0;
      ai_q  <= 1'b0;
      bi_q  <= 1'b0;
      an_q  <= 1'b0;
      bn_q  <= 1'b0;
      e_q   <= '0;
      m_q   <= '0;
      g_q   <= 1'b0;
      s_q   <= 1'b0;
      inx_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          p_q   <= prod;
          sgn_q <= sign_a ^ sign_b;
          ea_q  <= exp_a;
          eb_q  <= exp_b;
          az_q  <= a_zero;
          bz_q  <= b_zero;
          ai_q  <= a_inf;
          bi_q  <= b_inf;
          an_q  <= a_nan;
          bn_q  <= b_nan;
        end
        NORM: begin
          if (p_q[PW-1]) begin
            m_q <= p_q[PW-1 -: MAN_W];
            g_q <= p_q[MAN_W-1];
            s_q <= |p_q[MAN_W-2:0];
            e_q <= e_base + E_ONE;
          end else begin
            m_q <= p_q[PW-2 -: MAN_W];
            g_q <= p_q[MAN_W-2];
            s_q <= |p_q[MAN_W-3:0];
            e_q <= e_base;
          end
        end
        ROUND: begin
          inx_q <= g_q | s_q;
          if (rnd_up) begin
            if (m_inc[MAN_W]) begin
              m_q <= {1'b1, {(MAN_W-1){1'b0}}};
              e_q <= e_q + E_ONE;
            end else begin
              m_q <= m_inc[MAN_W-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      result   <= '0;
      flag_ovf <= 1'b0;
      flag_unf <= 1'b0;
      flag_inx <= 1'b0;
      flag_inv <= 1'b0;
    end else if (state == PACK) begin
      result   <= res_nxt;
      flag_ovf <= ovf_nxt;
      flag_unf <= unf_nxt;
      flag_inx <= inx_nxt;
      flag_inv <= inv_nxt;
    end
  end

endmodule
